// File: rtl/spi_qram_slave.sv
// SPI/QSPI RAM target for the pico-ice test designs.
// The master drives spi_clk, spi_select and the data pins. Inputs are sampled
// on the rising edge of spi_clk and outputs are updated on the falling edge.
// spi_select high deselects the target and asynchronously clears all
// transaction state. RAM contents and last_was_quad survive a deselect.
//
// Ports:
//   spi_clk    - SPI clock, the only clock
//   spi_select - chip select, high = deselected (async clear)
//   spi_d_in   - D0..D3 pin inputs (D0 = MOSI in single mode)
//   spi_d_out  - pin outputs (single mode drives MISO on bit 1)
//   spi_d_oe   - per-pin output enables
//   cmd_code   - command byte of the current transaction (0 until received)
//   cmd_valid  - high once a supported command has been decoded
//
// Commands: 03h read, 02h write, 6Bh quad read, 32h quad write,
//           9Fh JEDEC ID, 05h status. Anything else is ignored.
module spi_qram_slave #(
  parameter int          RAM_ADDR_BITS   = 6,
  parameter int          ADDR_BYTES      = 3,
  parameter int          FAST_READ_DUMMY = 2,
  parameter logic [23:0] JEDEC_ID        = 24'hEF4017
) (
  input  logic       spi_clk,
  input  logic       spi_select,
  input  logic [3:0] spi_d_in,
  output logic [3:0] spi_d_out,
  output logic [3:0] spi_d_oe,
  output logic [7:0] cmd_code,
  output logic       cmd_valid
);

  localparam int ADDR_EDGES = 8 * ADDR_BYTES;
  localparam int DEPTH      = 1 << RAM_ADDR_BITS;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QREAD  = 8'h6B;
  localparam logic [7:0] CMD_QWRITE = 8'h32;
  localparam logic [7:0] CMD_ID     = 8'h9F;
  localparam logic [7:0] CMD_STATUS = 8'h05;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STATUS, S_IGNORE
  } state_t;

  typedef enum logic [1:0] {
    OP_READ, OP_WRITE, OP_QREAD, OP_QWRITE
  } op_t;

  state_t                   state, state_n;
  op_t                      op, op_n;
  logic [5:0]               cnt, cnt_n;
  logic [2:0]               pos, pos_n;
  logic [6:0]               sr, sr_n;
  logic [RAM_ADDR_BITS-1:0] addr, addr_n;
  logic [1:0]               id_idx, id_idx_n;
  logic [7:0]               code_n;
  logic                     valid_n;
  logic [3:0]               oe_n;
  logic                     lwq_n;
  logic [3:0]               out_n;

  // Only state that survives deselect; power-up value 0.
  logic                     last_was_quad = 1'b0;

  logic [7:0]               mem [DEPTH];

  logic [7:0]               cmd_byte;
  logic [7:0]               wbyte;
  logic [7:0]               tx_byte;
  logic [7:0]               id_byte;
  logic                     quad;
  logic                     byte_done;
  logic                     ram_we;

  assign cmd_byte  = {sr, spi_d_in[0]};
  assign quad      = (op == OP_QREAD) || (op == OP_QWRITE);
  assign byte_done = quad ? (pos == 3'd1) : (pos == 3'd7);
  assign ram_we    = (state == S_DATA) && ((op == OP_WRITE) || (op == OP_QWRITE));

  // Transaction state register.
  always_ff @(posedge spi_clk or posedge spi_select) begin
    if (spi_select) begin
      state     <= S_CMD;
      op        <= OP_READ;
      cnt       <= '0;
      pos       <= '0;
      sr        <= '0;
      addr      <= '0;
      id_idx    <= '0;
      cmd_code  <= '0;
      cmd_valid <= 1'b0;
      spi_d_oe  <= '0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      cnt       <= cnt_n;
      pos       <= pos_n;
      sr        <= sr_n;
      addr      <= addr_n;
      id_idx    <= id_idx_n;
      cmd_code  <= code_n;
      cmd_valid <= valid_n;
      spi_d_oe  <= oe_n;
    end
  end

  // Next-state logic. pos is the bit (or nibble) index within the current
  // byte; it advances on every rising edge of the data phase, so the falling
  // edge that follows already sees the index of the next bit to drive.
  always_comb begin
    state_n  = state;
    op_n     = op;
    cnt_n    = cnt;
    pos_n    = pos;
    sr_n     = sr;
    addr_n   = addr;
    id_idx_n = id_idx;
    code_n   = cmd_code;
    valid_n  = cmd_valid;
    oe_n     = spi_d_oe;
    lwq_n    = last_was_quad;

    case (state)
      S_CMD: begin
        sr_n  = {sr[5:0], spi_d_in[0]};
        cnt_n = cnt + 6'd1;
        if (cnt == 6'd7) begin
          code_n = cmd_byte;
          cnt_n  = '0;
          pos_n  = '0;
          case (cmd_byte)
            CMD_READ: begin
              op_n = OP_READ;   state_n = S_ADDR; valid_n = 1'b1; lwq_n = 1'b0;
            end
            CMD_WRITE: begin
              op_n = OP_WRITE;  state_n = S_ADDR; valid_n = 1'b1; lwq_n = 1'b0;
            end
            CMD_QREAD: begin
              op_n = OP_QREAD;  state_n = S_ADDR; valid_n = 1'b1; lwq_n = 1'b1;
            end
            CMD_QWRITE: begin
              op_n = OP_QWRITE; state_n = S_ADDR; valid_n = 1'b1; lwq_n = 1'b1;
            end
            CMD_ID: begin
              state_n = S_ID; valid_n = 1'b1; oe_n = 4'b0010; id_idx_n = '0;
            end
            CMD_STATUS: begin
              state_n = S_STATUS; valid_n = 1'b1; oe_n = 4'b0010;
            end
            default: state_n = S_IGNORE;
          endcase
        end
      end

      S_ADDR: begin
        // Upper address bits simply shift out of the register.
        addr_n = {addr[RAM_ADDR_BITS-2:0], spi_d_in[0]};
        cnt_n  = cnt + 6'd1;
        if (cnt == 6'(ADDR_EDGES - 1)) begin
          cnt_n = '0;
          pos_n = '0;
          if (op == OP_QREAD) begin
            state_n = S_DUMMY;
          end else begin
            state_n = S_DATA;
            if (op == OP_READ) oe_n = 4'b0010;
          end
        end
      end

      S_DUMMY: begin
        cnt_n = cnt + 6'd1;
        if (cnt == 6'(FAST_READ_DUMMY - 1)) begin
          state_n = S_DATA;
          oe_n    = 4'b1111;
        end
      end

      S_DATA: begin
        if (byte_done) begin
          pos_n  = '0;
          addr_n = addr + 1'b1;
        end else begin
          pos_n = pos + 3'd1;
        end
      end

      S_ID: begin
        if (pos == 3'd7) begin
          pos_n    = '0;
          id_idx_n = (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
        end else begin
          pos_n = pos + 3'd1;
        end
      end

      S_STATUS: pos_n = pos + 3'd1;

      default: ;
    endcase
  end

  // Status flag: updated only when a read/write command is decoded.
  always_ff @(posedge spi_clk) begin
    if (!spi_select) last_was_quad <= lwq_n;
  end

  // Bit/nibble-immediate write merge into the current byte.
  always_comb begin
    wbyte = mem[addr];
    if (op == OP_QWRITE) begin
      if (pos[0]) wbyte[3:0] = spi_d_in;
      else        wbyte[7:4] = spi_d_in;
    end else begin
      wbyte[3'd7 - pos] = spi_d_in[0];
    end
  end

  // RAM has no reset; deselect blocks a coincident write.
  always_ff @(posedge spi_clk) begin
    if (ram_we && !spi_select) mem[addr] <= wbyte;
  end

  // Output data selection.
  always_comb begin
    case (id_idx)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      default: id_byte = JEDEC_ID[7:0];
    endcase

    case (state)
      S_ID:     tx_byte = id_byte;
      S_STATUS: tx_byte = {7'b0, last_was_quad};
      default:  tx_byte = mem[addr];
    endcase

    out_n = '0;
    case (state)
      S_DATA: begin
        if (op == OP_READ)       out_n[1] = tx_byte[3'd7 - pos];
        else if (op == OP_QREAD) out_n    = pos[0] ? tx_byte[3:0] : tx_byte[7:4];
      end
      S_ID, S_STATUS: out_n[1] = tx_byte[3'd7 - pos];
      default: ;
    endcase
  end

  always_ff @(negedge spi_clk or posedge spi_select) begin
    if (spi_select) spi_d_out <= '0;
    else            spi_d_out <= out_n;
  end

endmodule

// File: tb/tb_spi_qram_slave.sv
// Self-checking bench for spi_qram_slave: a default instance and a small
// instance (ADDR_BYTES=1, RAM_ADDR_BITS=4, FAST_READ_DUMMY=4) share the clock
// and data pins but have separate selects. A driver issues transactions and
// pushes expected read bytes into a queue; a monitor assembles the sampled
// MISO bits / nibbles into bytes and compares them against the queue.
module tb_spi_qram_slave;

  localparam int K_READ   = 0;
  localparam int K_QREAD  = 1;
  localparam int K_ID     = 2;
  localparam int K_STATUS = 3;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    logic [7:0] data;
    logic [3:0] oe;
    string      name;
  } exp_t;

  logic       spi_clk = 1'b0;
  logic [1:0] sel     = 2'b11;
  logic [3:0] d_in    = 4'h0;
  logic [3:0] out0, oe0, out1, oe1;
  logic [7:0] code0, code1;
  logic       valid0, valid1;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;

  logic [7:0]  mdl [2][64];
  bit          lwq [2]    = '{1'b0, 1'b0};
  int unsigned abytes [2] = '{3, 1};
  int unsigned abits  [2] = '{6, 4};
  int unsigned ndummy [2] = '{2, 4};
  logic [7:0]  jedec  [3] = '{8'hEF, 8'h40, 8'h17};

  exp_t exp_q[$];
  bit   cap_on   = 1'b0;
  int   cap_dut  = 0;
  bit   cap_quad = 1'b0;

  always #5 spi_clk = ~spi_clk;

  spi_qram_slave dut0 (
    .spi_clk    (spi_clk),
    .spi_select (sel[0]),
    .spi_d_in   (d_in),
    .spi_d_out  (out0),
    .spi_d_oe   (oe0),
    .cmd_code   (code0),
    .cmd_valid  (valid0)
  );

  spi_qram_slave #(
    .RAM_ADDR_BITS   (4),
    .ADDR_BYTES      (1),
    .FAST_READ_DUMMY (4),
    .JEDEC_ID        (24'hEF4017)
  ) dut1 (
    .spi_clk    (spi_clk),
    .spi_select (sel[1]),
    .spi_d_in   (d_in),
    .spi_d_out  (out1),
    .spi_d_oe   (oe1),
    .cmd_code   (code1),
    .cmd_valid  (valid1)
  );

  function automatic logic [3:0] oe_of(input int dut);
    return (dut == 1) ? oe1 : oe0;
  endfunction

  function automatic logic [3:0] out_of(input int dut);
    return (dut == 1) ? out1 : out0;
  endfunction

  function automatic logic [7:0] code_of(input int dut);
    return (dut == 1) ? code1 : code0;
  endfunction

  function automatic logic valid_of(input int dut);
    return (dut == 1) ? valid1 : valid0;
  endfunction

  function automatic bq_t rand_bytes(input int unsigned n);
    bq_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive pins, let the DUT sample on the rising edge, return on the falling edge.
  task automatic clk_edge(input logic [3:0] d);
    d_in = d;
    @(posedge spi_clk);
    edge_no++;
    @(negedge spi_clk);
  endtask

  // Send v[n-1:0] MSB first on D0.
  task automatic send_bits(input logic [31:0] v, input int unsigned n);
    for (int unsigned i = n; i > 0; i--) clk_edge({3'b0, v[i-1]});
  endtask

  task automatic begin_x(input int dut);
    sel[dut] = 1'b0;
    edge_no  = 0;
  endtask

  task automatic end_x(input int dut);
    sel[dut] = 1'b1;
    d_in     = 4'h0;
    #1;
    check($sformatf("oe_deselect_d%0d", dut), 32'(oe_of(dut)), 32'h0);
    check($sformatf("out_deselect_d%0d", dut), 32'(out_of(dut)), 32'h0);
    check($sformatf("valid_deselect_d%0d", dut), 32'(valid_of(dut)), 32'h0);
    @(negedge spi_clk);
    @(negedge spi_clk);
  endtask

  // Write nunits bits (single) or nibbles (quad) taken MSB first from data;
  // the model is updated unit by unit so partial bytes behave like the pins.
  task automatic do_write(input int dut, input bit quad, input logic [31:0] addr,
                          input bq_t data, input int unsigned nunits);
    int unsigned depth, upb, a;
    logic [7:0]  b;
    logic [3:0]  nib;
    depth = 1 << abits[dut];
    upb   = quad ? 2 : 8;
    begin_x(dut);
    send_bits(quad ? 32'h32 : 32'h02, 8);
    send_bits(addr, 8 * abytes[dut]);
    check($sformatf("wr_oe_d%0d", dut), 32'(oe_of(dut)), 32'h0);
    lwq[dut] = quad;
    for (int unsigned u = 0; u < nunits; u++) begin
      a = (addr % depth + u / upb) % depth;
      b = data[u / upb];
      if (quad) begin
        nib = (u % 2 == 0) ? b[7:4] : b[3:0];
        clk_edge(nib);
        if (u % 2 == 0) mdl[dut][a][7:4] = nib;
        else            mdl[dut][a][3:0] = nib;
      end else begin
        clk_edge({3'b0, b[7 - u % 8]});
        mdl[dut][a][7 - u % 8] = b[7 - u % 8];
      end
    end
    end_x(dut);
  endtask

  task automatic do_read(input int dut, input int kind, input logic [31:0] addr,
                         input int unsigned nbytes);
    logic [7:0]  cmd;
    logic [3:0]  oe_exp;
    int unsigned depth, aedges;
    exp_t        x;
    depth  = 1 << abits[dut];
    aedges = 8 * abytes[dut];
    case (kind)
      K_READ:  begin cmd = 8'h03; oe_exp = 4'b0010; end
      K_QREAD: begin cmd = 8'h6B; oe_exp = 4'b1111; end
      K_ID:    begin cmd = 8'h9F; oe_exp = 4'b0010; end
      default: begin cmd = 8'h05; oe_exp = 4'b0010; end
    endcase
    begin_x(dut);
    send_bits(32'(cmd) >> 1, 7);
    check($sformatf("code_e7_%02h", cmd), 32'(code_of(dut)), 32'h0);
    if (kind >= K_ID) check($sformatf("oe_e7_%02h", cmd), 32'(oe_of(dut)), 32'h0);
    send_bits(32'(cmd), 1);
    check($sformatf("code_e8_%02h", cmd), 32'(code_of(dut)), 32'(cmd));
    check($sformatf("valid_e8_%02h", cmd), 32'(valid_of(dut)), 32'h1);
    if (kind >= K_ID) begin
      check($sformatf("oe_e8_%02h", cmd), 32'(oe_of(dut)), 32'(oe_exp));
    end else begin
      lwq[dut] = (kind == K_QREAD);
      send_bits(addr >> 1, aedges - 1);
      check($sformatf("oe_e%0d_%02h", edge_no, cmd), 32'(oe_of(dut)), 32'h0);
      send_bits(addr, 1);
      if (kind == K_READ) begin
        check($sformatf("oe_e%0d_%02h", edge_no, cmd), 32'(oe_of(dut)), 32'(oe_exp));
      end else begin
        send_bits(32'h0, ndummy[dut] - 1);
        check($sformatf("oe_e%0d_%02h", edge_no, cmd), 32'(oe_of(dut)), 32'h0);
        send_bits(32'h0, 1);
        check($sformatf("oe_e%0d_%02h", edge_no, cmd), 32'(oe_of(dut)), 32'(oe_exp));
      end
    end
    for (int unsigned i = 0; i < nbytes; i++) begin
      if (kind <= K_QREAD)  x.data = mdl[dut][(addr % depth + i) % depth];
      else if (kind == K_ID) x.data = jedec[i % 3];
      else                   x.data = {7'b0, lwq[dut]};
      x.oe   = oe_exp;
      x.name = $sformatf("rd_d%0d_%02h_b%0d", dut, cmd, i);
      exp_q.push_back(x);
    end
    cap_dut  = dut;
    cap_quad = (kind == K_QREAD);
    cap_on   = 1'b1;
    repeat (nbytes * (cap_quad ? 2 : 8)) clk_edge(4'($urandom));
    cap_on = 1'b0;
    end_x(dut);
  endtask

  // Monitor: samples one rising edge later than the DUT drives, assembles
  // bytes and checks them (data and output enable) against the queue.
  initial begin : monitor
    logic [7:0] acc;
    logic [3:0] o, e, oe_obs;
    bit         oe_err;
    int         nbits;
    exp_t       x;
    acc = '0; oe_obs = '0; oe_err = 1'b0; nbits = 0;
    forever begin
      @(posedge spi_clk);
      #1;
      if (!cap_on) begin
        nbits = 0;
      end else begin
        o = (cap_dut == 1) ? out1 : out0;
        e = (cap_dut == 1) ? oe1 : oe0;
        if (nbits == 0) begin
          oe_obs = e;
          oe_err = 1'b0;
        end
        if (!oe_err && exp_q.size() > 0 && e !== exp_q[0].oe) begin
          oe_obs = e;
          oe_err = 1'b1;
        end
        if (cap_quad) begin
          acc   = {acc[3:0], o};
          nbits += 4;
        end else begin
          acc   = {acc[6:0], o[1]};
          nbits += 1;
        end
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %02h, expected nothing", acc);
          end else begin
            x = exp_q.pop_front();
            check(x.name, 32'(acc), 32'(x.data));
            check({x.name, "_oe"}, 32'(oe_obs), 32'(x.oe));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    bq_t        q;
    logic [3:0] oe_or;
    int         dut, kind;
    int unsigned nb, upb;

    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_oe_d%0d", d), 32'(oe_of(d)), 32'h0);
      check($sformatf("rst_out_d%0d", d), 32'(out_of(d)), 32'h0);
      check($sformatf("rst_code_d%0d", d), 32'(code_of(d)), 32'h0);
      check($sformatf("rst_valid_d%0d", d), 32'(valid_of(d)), 32'h0);
    end
    @(negedge spi_clk);

    // Power-up status is 0.
    do_read(0, K_STATUS, 0, 1);

    // Give both RAMs known contents.
    do_write(0, 1'b0, 32'h0, rand_bytes(64), 64 * 8);
    do_write(1, 1'b0, 32'h0, rand_bytes(16), 16 * 8);

    // Single write then read.
    q = {8'hA5, 8'h3C};
    do_write(0, 1'b0, 32'h000010, q, 16);
    do_read(0, K_READ, 32'h000010, 2);

    // Quad write and quad read across the wrap point.
    q = {8'h12, 8'h34};
    do_write(0, 1'b1, 32'h00003F, q, 4);
    do_read(0, K_QREAD, 32'h00003F, 2);

    // Status after quad traffic, then after a single read.
    do_read(0, K_STATUS, 0, 2);
    do_read(0, K_READ, 32'h000020, 1);
    do_read(0, K_STATUS, 0, 2);

    // JEDEC ID repeats after three bytes.
    do_read(0, K_ID, 0, 4);

    // Unsupported command: no drive, no writes.
    begin_x(0);
    send_bits(32'hFF, 8);
    check("bad_code", 32'(code0), 32'hFF);
    check("bad_valid", 32'(valid0), 32'h0);
    oe_or = oe0;
    repeat (40) begin
      clk_edge({3'b0, 1'($urandom)});
      oe_or = oe_or | oe0;
    end
    check("bad_oe_any", 32'(oe_or), 32'h0);
    check("bad_valid_end", 32'(valid0), 32'h0);
    end_x(0);
    do_read(0, K_READ, 32'h0, 64);

    // Deselect in the middle of a byte.
    q = {8'h00};
    do_write(0, 1'b0, 32'h000005, q, 8);
    q = {8'hFF};
    do_write(0, 1'b0, 32'h000005, q, 4);
    do_read(0, K_READ, 32'h000005, 1);

    // Small instance: wrap with 16-byte RAM, 1 address byte, 4 dummy cycles.
    q = {8'h11, 8'h22, 8'h33};
    do_write(1, 1'b0, 32'h0E, q, 24);
    do_read(1, K_QREAD, 32'h0E, 3);
    do_read(1, K_READ, 32'h00, 1);
    do_read(1, K_ID, 0, 3);

    // Random traffic on both instances.
    for (int it = 0; it < 40; it++) begin
      dut  = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      nb   = $urandom_range(1, 5);
      case (kind)
        0, 1: begin
          upb = (kind == 1) ? 2 : 8;
          do_write(dut, kind == 1, $urandom, rand_bytes(nb),
                   nb * upb - $urandom_range(0, upb - 1));
        end
        2:       do_read(dut, K_READ, $urandom, nb);
        3:       do_read(dut, K_QREAD, $urandom, nb);
        4:       do_read(dut, K_ID, 0, nb);
        default: do_read(dut, K_STATUS, 0, nb);
      endcase
    end

    // Final readback of both RAMs.
    do_read(0, K_READ, 32'h0, 64);
    do_read(1, K_QREAD, 32'h0, 16);

    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
